// File: rtl/uart_tx_queue_if.sv
// Start/ready handshake between the transmit queue and the uart_tx serializer.
interface uart_tx_queue_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_start, output tx_data, input tx_ready);
    modport slave  (input tx_start, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_queue.sv
// Memory-mapped transmit FIFO plus sequencer that feeds bytes to uart_tx one frame at a time.
module uart_tx_queue #(
    parameter logic [27:0]  BASE  = 28'h000_0004,
    parameter int unsigned  DEPTH = 16,
    parameter int unsigned  AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      MADDR,
    inout  wire  [31:0]      MDATA,
    input  logic             MEN,
    input  logic             MRW,
    output wire              MWAIT,
    uart_tx_queue_if.master  tx
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY
    } state_e;

    state_e          state_q;
    logic            tx_start_q;
    logic [7:0]      tx_data_q;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            enable_q, enable_d;

    logic            q_en;
    logic [1:0]      offset;
    logic            wr_status, wr_data, wr_ctrl;
    logic            flush, ovf_clr, push, pop, full, accept, push_ok;
    logic            busy;
    logic [31:0]     rdata;
    logic            unused_bits;

    // Bus decode: four word registers in the window
    assign q_en      = MEN && (MADDR[31:4] == BASE);
    assign offset    = MADDR[3:2];
    assign wr_status = q_en && MRW && (offset == 2'd0);
    assign wr_data   = q_en && MRW && (offset == 2'd1);
    assign wr_ctrl   = q_en && MRW && (offset == 2'd2);

    assign flush     = wr_status && MDATA[0];
    assign ovf_clr   = wr_status && MDATA[1];
    assign push      = wr_data;
    assign pop       = (state_q == S_IDLE) && enable_q && (count_q != '0) && tx.tx_ready;
    assign full      = (count_q == CW'(DEPTH));
    assign accept    = !full || pop;
    assign push_ok   = push && accept && !flush;
    assign busy      = (state_q != S_IDLE);

    assign unused_bits = ^{MADDR[1:0], MDATA[31:8]};

    // FIFO bookkeeping and control registers; flush overrides any push
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        enable_d   = enable_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop)
                count_d = count_q + CW'(1);
            else if (pop && !push_ok)
                count_d = count_q - CW'(1);
        end

        if (ovf_clr)
            overflow_d = 1'b0;
        else if (push && !flush && !accept)
            overflow_d = 1'b1;

        if (wr_ctrl) enable_d = MDATA[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b1;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            enable_q   <= enable_d;
        end
    end

    // Storage needs no reset: reads are qualified by count
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= MDATA[7:0];
    end

    // Sequencer: pop in IDLE, hold start until the serializer drops ready, wait for ready again
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        tx_start_q <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (!tx.tx_ready) begin
                        tx_start_q <= 1'b0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    tx_start_q <= 1'b0;
                    if (tx.tx_ready) state_q <= S_IDLE;
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_start = tx_start_q;
    assign tx.tx_data  = tx_data_q;

    // Read mux; DATA peeks at the head without popping
    always_comb begin
        rdata = 32'd0;
        case (offset)
            2'd0:    rdata = 32'({enable_q, overflow_q, busy, count_q});
            2'd1:    rdata = (count_q == '0) ? 32'd0 : 32'(mem_q[rd_ptr_q]);
            2'd2:    rdata = 32'(enable_q);
            default: rdata = 32'd0;
        endcase
    end

    assign MDATA = (q_en && !MRW) ? rdata : 32'hzzzzzzzz;
    assign MWAIT = q_en ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed + randomized bench for uart_tx_queue with a queue-based reference model and a uart_tx ready model.
module tb_uart_tx_queue;

    localparam logic [31:0] A_STATUS = 32'h40;
    localparam logic [31:0] A_DATA   = 32'h44;
    localparam logic [31:0] A_CTRL   = 32'h48;
    localparam logic [31:0] A_RSVD   = 32'h4C;

    logic        clk;
    logic        rst;
    logic [31:0] maddr;
    wire  [31:0] mdata;
    logic        men;
    logic        mrw;
    wire         mwait;
    logic        tb_oe;
    logic [31:0] tb_wd;

    uart_tx_queue_if txif ();

    assign mdata = tb_oe ? tb_wd : 32'hzzzzzzzz;

    uart_tx_queue dut (
        .clk   (clk),
        .rst   (rst),
        .MADDR (maddr),
        .MDATA (mdata),
        .MEN   (men),
        .MRW   (mrw),
        .MWAIT (mwait),
        .tx    (txif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total  = 0;
    int          passed = 0;
    logic [7:0]  mq [$];
    bit          m_ovf;
    int          sent_cnt = 0;
    int          rises    = 0;
    int          frames   = 0;
    bit          uart_auto = 1'b0;
    logic        last_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] status_exp(input bit en, input bit busy);
        return 32'({en, m_ovf, busy, 5'(mq.size())});
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        maddr = a; men = 1'b1; mrw = 1'b1; tb_oe = 1'b1; tb_wd = d;
        @(posedge clk); #1;
        men = 1'b0; mrw = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        maddr = a; men = 1'b1; mrw = 1'b0; tb_oe = 1'b0;
        #1;
        d = mdata;
        last_wait = mwait;
        @(posedge clk); #1;
        men = 1'b0;
    endtask

    // Reference FIFO: accept when there is room, or when the sequencer pops in the same cycle
    task automatic push(input logic [7:0] b, input bit pop_same);
        bus_write(A_DATA, 32'(b));
        if (mq.size() < 16 || pop_same) mq.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic wait_sent(input int n, input int budget);
        for (int i = 0; i < budget && sent_cnt < n; i++) @(posedge clk);
        chk("frames_started", 32'(sent_cnt), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] d;
        for (int i = 0; i < budget; i++) begin
            bus_read(A_STATUS, d);
            if (!d[5]) break;
        end
    endtask

    // uart_tx model: ready drops a few cycles after start and returns 20 cycles later
    initial begin
        txif.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (uart_auto && txif.tx_start && txif.tx_ready) begin
                repeat (2) @(posedge clk);
                #1; txif.tx_ready = 1'b0;
                frames++;
                repeat (20) @(posedge clk);
                #1; txif.tx_ready = 1'b1;
            end
        end
    end

    // Frame monitor: each start rise must carry the next expected byte, held until the frame ends
    logic       prev_start = 1'b0;
    logic       prev_ready = 1'b1;
    logic [7:0] cur_byte   = 8'h00;
    always @(negedge clk) begin
        if (!rst && txif.tx_start && !prev_start) begin
            logic [8:0] exp9;
            rises++;
            sent_cnt++;
            exp9 = (mq.size() > 0) ? {1'b0, mq.pop_front()} : 9'h100;
            cur_byte = txif.tx_data;
            chk("tx_data_order", 32'({1'b0, txif.tx_data}), 32'(exp9));
        end
        if (!rst && txif.tx_ready && !prev_ready)
            chk("tx_data_stable", 32'(txif.tx_data), 32'(cur_byte));
        prev_start = txif.tx_start;
        prev_ready = txif.tx_ready;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  first;
        int          base, n;

        maddr = 32'h0; men = 1'b0; mrw = 1'b0; tb_oe = 1'b0; tb_wd = 32'h0;
        m_ovf = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        bus_read(A_STATUS, d);  chk("reset_status", d, 32'h0000_0080);
        chk("mwait_decoded", 32'(last_wait), 32'h0);
        bus_read(A_CTRL, d);    chk("reset_ctrl", d, 32'h1);
        bus_read(A_DATA, d);    chk("empty_data", d, 32'h0);
        bus_read(A_RSVD, d);    chk("rsvd_read", d, 32'h0);
        chk("reset_tx_start", 32'(txif.tx_start), 32'h0);
        chk("reset_tx_data", 32'(txif.tx_data), 32'h0);

        // Three frames, count observed mid-frame
        uart_auto = 1'b1;
        bus_write(A_CTRL, 32'h0);
        push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b0);
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        bus_read(A_STATUS, d);  chk("three_queued", d, status_exp(1'b0, 1'b0));
        bus_write(A_CTRL, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            wait_sent(k, 200);
            repeat (2) @(posedge clk);
            bus_read(A_STATUS, d);  chk("count_mid_frame", d, status_exp(1'b1, 1'b1));
        end
        wait_idle(100);
        bus_read(A_STATUS, d);  chk("after_three", d, status_exp(1'b1, 1'b0));

        // Overflow with sequencer disabled, then drain in order
        base = sent_cnt;
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i == 0) first = b;
            push(b, 1'b0);
        end
        bus_read(A_STATUS, d);  chk("overflow_status", d, status_exp(1'b0, 1'b0));
        chk("overflow_flag_model", 32'(d[6]), 32'h1);
        bus_read(A_CTRL, d);    chk("ctrl_disabled", d, 32'h0);
        bus_read(A_DATA, d);    chk("data_peek", d, 32'(first));
        bus_read(A_DATA, d);    chk("data_peek_no_pop", d, 32'(first));
        chk("no_start_disabled", 32'(txif.tx_start), 32'h0);
        bus_write(A_CTRL, 32'h1);
        wait_sent(base + 16, 1200);
        wait_idle(100);
        bus_read(A_STATUS, d);  chk("overflow_sticky", d, status_exp(1'b1, 1'b0));
        bus_write(A_STATUS, 32'h2); m_ovf = 1'b0;
        bus_read(A_STATUS, d);  chk("overflow_cleared", d, status_exp(1'b1, 1'b0));

        // Full FIFO: push lands in the same cycle as the first pop
        base = sent_cnt;
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < 16; i++) push(8'($urandom), 1'b0);
        bus_write(A_CTRL, 32'h1);
        push(8'($urandom), 1'b1);
        bus_read(A_STATUS, d);  chk("full_push_pop", d, 32'h0000_00B0);
        chk("full_push_pop_model", d, status_exp(1'b1, 1'b1));
        wait_sent(base + 17, 1200);
        wait_idle(100);
        bus_read(A_STATUS, d);  chk("after_full", d, status_exp(1'b1, 1'b0));

        // Flush with clear-overflow while a frame is in BUSY
        base = sent_cnt;
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < 6; i++) push(8'($urandom), 1'b0);
        bus_write(A_CTRL, 32'h1);
        wait_sent(base + 1, 200);
        for (int i = 0; i < 50 && txif.tx_ready; i++) @(posedge clk);
        chk("frame_in_busy", 32'(txif.tx_ready), 32'h0);
        bus_write(A_STATUS, 32'h3);
        mq.delete(); m_ovf = 1'b0;
        bus_read(A_STATUS, d);  chk("flush_status", d, 32'h0000_00A0);
        wait_idle(100);
        repeat (60) @(posedge clk);
        chk("no_start_after_flush", 32'(sent_cnt), 32'(base + 1));
        bus_read(A_STATUS, d);  chk("flush_idle", d, status_exp(1'b1, 1'b0));

        // Random pushes with random gaps while the sequencer runs
        base = sent_cnt;
        n = $urandom_range(5, 9);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            push(8'($urandom), 1'b0);
        end
        wait_sent(base + n, 1500);
        wait_idle(100);
        bus_read(A_STATUS, d);  chk("random_idle", d, status_exp(1'b1, 1'b0));
        chk("one_start_per_frame", 32'(rises), 32'(frames));

        // Reset while holding START
        uart_auto = 1'b0;
        repeat (3) @(posedge clk);
        base = sent_cnt;
        push(8'($urandom), 1'b0);
        push(8'($urandom), 1'b0);
        wait_sent(base + 1, 100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("held_start", 32'(txif.tx_start), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete(); m_ovf = 1'b0;
        @(negedge clk);
        chk("rst_tx_start", 32'(txif.tx_start), 32'h0);
        bus_read(A_STATUS, d);  chk("rst_status", d, status_exp(1'b1, 1'b0));
        repeat (10) @(posedge clk);
        chk("no_start_after_rst", 32'(sent_cnt), 32'(base + 1));

        // Out-of-window read: the bench holds MDATA at zero and nothing else may drive it
        @(negedge clk);
        maddr = 32'h50; men = 1'b1; mrw = 1'b0; tb_oe = 1'b1; tb_wd = 32'h0;
        #1;
        chk("no_drive_outside", mdata, 32'h0);
        @(posedge clk); #1;
        men = 1'b0; tb_oe = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
